ft2232_fifo_arbiter: RTL and testbench
======================================

# ft2232_fifo_arbiter

Schedules the single shared FT2232H 245-synchronous FIFO bus between the host→FPGA receive stream (playback samples, commands) and the FPGA→host transmit stream (capture samples, status). Runs in the FT2232-sourced `fifo_clk` domain directly behind the top-level tristate pad. It sequences bus direction, inserts turnaround cycles, enforces per-direction burst limits for fairness, and absorbs the read pipeline overrun in a 2-entry skid buffer. Application logic sees two valid/ready byte streams.

## Interface
- `RX_BURST_MAX`, 64: maximum bytes read per RX grant (≥1).
- `TX_BURST_MAX`, 64: maximum bytes written per TX grant (≥1).
- `SIWU_IDLE_CYCLES`, 32: idle TX cycles before a send-immediate flush (only with the macro).
- `fifo_clk_i`  in  1: FT2232 60 MHz FIFO clock; the only clock.
- `reset_n_i`  in  1: asynchronous, active-low reset.
- `fifo_rxf_n_i`  in  1: FT2232 has RX data (low).
- `fifo_txe_n_i`  in  1: FT2232 can accept TX data (low).
- `fifo_data_i`  in  8: bus input from the pad.
- `fifo_data_o`  out  8: bus output to the pad.
- `fifo_data_oe_o`  out  1: pad drive enable, 1 = FPGA drives.
- `fifo_oe_n_o`, `fifo_rd_n_o`, `fifo_wr_n_o`, `fifo_siwu_o`  out  1 each: FT2232 controls, active-low.
- `rx_data_o`  out  8, `rx_valid_o`  out  1, `rx_ready_i`  in  1: receive stream.
- `tx_data_i`  in  8, `tx_valid_i`  in  1, `tx_ready_o`  out  1: transmit stream.

## Operation
- States: IDLE, RX_OE, RX_READ, TX_WRITE, TURN.
- IDLE: the RX request is `!fifo_rxf_n_i` with skid occupancy 0. The TX request is `tx_valid_i && !fifo_txe_n_i`.
  - Both requesting: grant the direction opposite `last_grant`.
  - One requesting: grant it.
  - RX grant → RX_OE. TX grant → TX_WRITE. `last_grant` is updated on each grant.
- RX_OE: `fifo_oe_n_o`=0 for exactly one cycle. `fifo_rd_n_o` stays 1. Then → RX_READ.
- RX_READ: `fifo_oe_n_o`=0. `fifo_rd_n_o` is registered.
  - A byte is pushed into the skid on every edge where `fifo_rd_n_o`=0 and `fifo_rxf_n_i`=0.
  - `fifo_rd_n_o` is low in the next cycle only if all hold: `fifo_rxf_n_i`=0, post-edge occupancy ≤1, and RX burst count <`RX_BURST_MAX`.
  - When `fifo_rd_n_o` is high and no byte was pushed that edge: go to TURN. `fifo_oe_n_o` returns to 1 in TURN.
- TX_WRITE: `fifo_data_oe_o`=1, `fifo_data_o`=`tx_data_i`.
  - `tx_ready_o` = `!fifo_txe_n_i && tx_burst < TX_BURST_MAX` (combinational).
  - `fifo_wr_n_o` = `!(tx_valid_i && tx_ready_o)`.
  - Exit to TURN when `tx_valid_i`=0, `fifo_txe_n_i`=1, or the burst limit is reached.
- TURN: all controls high, `fifo_data_oe_o`=0, for one cycle. Then → IDLE.
- Skid: 2-entry FIFO. `rx_valid_o` = occupancy>0 and `rx_data_o` = head. Pop when `rx_valid_o && rx_ready_i`. Push and pop in the same edge are allowed. Overflow must be impossible.
- Bus contention: `fifo_data_oe_o` and `fifo_oe_n_o`=0 are never asserted in the same cycle.

## Timing
- Reset values:
  - `fifo_oe_n_o`, `fifo_rd_n_o`, `fifo_wr_n_o`, `fifo_siwu_o` = 1.
  - `fifo_data_oe_o`=0, `fifo_data_o`=0.
  - `rx_valid_o`=0, `tx_ready_o`=0.
  - State IDLE, skid empty, burst counters 0, `last_grant`=TX (so RX wins first).
- RX latency: `fifo_rxf_n_i` falls → `fifo_oe_n_o` low at +1 → `fifo_rd_n_o` low at +2 → first byte at `rx_valid_o` at +3.
- Sustained RX throughput is 1 byte/cycle while `rx_ready_i`=1.
- TX: first byte is written in the cycle after the grant. Sustained throughput is 1 byte/cycle.
- Direction switch costs RX_OE + TURN, at least 2 dead cycles.
- `fifo_rxf_n_i` rising mid-burst: that edge pushes no byte and the block exits via TURN.
- Reset asserted mid-burst: all outputs return to reset values immediately, without waiting for a clock edge. Skid contents are discarded.

## Configuration
- `FT2232_SIWU_FLUSH_EN` defined: an idle counter runs after any TX byte and counts cycles with no TX transfer.
  - When the counter reaches `SIWU_IDLE_CYCLES`, `fifo_siwu_o` pulses low for one cycle while the block is in IDLE or TURN.
  - At most one pulse per TX activity period. The counter clears on the next TX byte.
- Not defined: `fifo_siwu_o` is tied to 1 and no counter logic exists.

## Test plan
- RX only, 200 bytes 0x00..0xC7, `rx_ready_i`=1: bytes arrive in order. RX_BURST_MAX=64 gives bursts of 64, 64, 64, 8, separated by RX_OE/TURN gaps.
- RX with `rx_ready_i` toggled every 3 cycles: no byte lost or duplicated, and skid occupancy never exceeds 2.
- TX only, 10 bytes, `fifo_txe_n_i` forced high after byte 4 for 5 cycles: exactly 4 `fifo_wr_n_o` strobes, then TURN, then the remaining 6 strobes. Data is unchanged.
- Both streams continuously pending: grants alternate RX,TX,RX,… in 64-byte bursts. `fifo_data_oe_o` and `fifo_oe_n_o`=0 never overlap.
- Reset pulse during an RX burst after byte 10: outputs reset asynchronously. After release, the RX stream restarts cleanly with no stale `rx_valid_o`.
- With `FT2232_SIWU_FLUSH_EN`, 3 TX bytes then idle: one `fifo_siwu_o` low pulse 32 cycles after the last write, with no repeat.

Source files
------------

// File: rtl/ft2232_fifo_arbiter.sv
// ft2232_fifo_arbiter
// -------------------
// Shares the single FT2232H 245-synchronous FIFO bus between the host->FPGA
// receive stream and the FPGA->host transmit stream. Lives in the
// FT2232-sourced fifo_clk domain directly behind the tristate pad. Sequences
// the bus direction, inserts turnaround cycles, limits the burst length per
// grant so neither direction starves the other, and absorbs the read pipeline
// overrun in a 2-entry skid buffer.
//
// Optional feature macro: FT2232_SIWU_FLUSH_EN
//   defined   : after TX activity goes quiet for SIWU_IDLE_CYCLES cycles,
//               fifo_siwu_o pulses low once (IDLE/TURN only) to flush the
//               FT2232 transmit buffer to the host.
//   undefined : fifo_siwu_o is tied high.
//
// Ports
//   fifo_clk_i        FT2232 60 MHz FIFO clock (only clock)
//   reset_n_i         asynchronous active-low reset
//   fifo_rxf_n_i      FT2232 holds RX data (active low)
//   fifo_txe_n_i      FT2232 can accept TX data (active low)
//   fifo_data_i       bus input from the pad
//   fifo_data_o       bus output to the pad
//   fifo_data_oe_o    pad drive enable, 1 = FPGA drives
//   fifo_oe_n_o       FT2232 output enable (active low)
//   fifo_rd_n_o       FT2232 read strobe (active low, registered)
//   fifo_wr_n_o       FT2232 write strobe (active low)
//   fifo_siwu_o       FT2232 send-immediate (active low)
//   rx_data_o/rx_valid_o/rx_ready_i   receive byte stream
//   tx_data_i/tx_valid_i/tx_ready_o   transmit byte stream

module ft2232_fifo_arbiter #(
    parameter int RX_BURST_MAX     = 64,
    parameter int TX_BURST_MAX     = 64,
    parameter int SIWU_IDLE_CYCLES = 32
) (
    input  logic       fifo_clk_i,
    input  logic       reset_n_i,
    input  logic       fifo_rxf_n_i,
    input  logic       fifo_txe_n_i,
    input  logic [7:0] fifo_data_i,
    output logic [7:0] fifo_data_o,
    output logic       fifo_data_oe_o,
    output logic       fifo_oe_n_o,
    output logic       fifo_rd_n_o,
    output logic       fifo_wr_n_o,
    output logic       fifo_siwu_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o
);

    localparam int RXW = $clog2(RX_BURST_MAX + 1);
    localparam int TXW = $clog2(TX_BURST_MAX + 1);
    localparam logic [RXW-1:0] RX_MAX_C = RXW'(RX_BURST_MAX);
    localparam logic [TXW-1:0] TX_MAX_C = TXW'(TX_BURST_MAX);

    if (RX_BURST_MAX < 1 || TX_BURST_MAX < 1 || SIWU_IDLE_CYCLES < 1) begin : g_bad_params
        $error("ft2232_fifo_arbiter: burst limits and SIWU idle count must be >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_OE,
        ST_RX_READ,
        ST_TX_WRITE,
        ST_TURN
    } state_t;

    state_t         state_q, state_d;
    logic           rd_n_q, rd_n_d;
    logic           last_tx_q, last_tx_d;      // 1 = last grant went to TX
    logic [RXW-1:0] rx_burst_q, rx_burst_d;
    logic [TXW-1:0] tx_burst_q, tx_burst_d;

    logic [7:0]     skid_mem_q [2];
    logic           skid_wr_ptr_q;
    logic           skid_rd_ptr_q;
    logic [1:0]     skid_cnt_q, skid_cnt_d;

    logic           push;
    logic           pop;
    logic           tx_xfer;
    logic           rx_req;
    logic           tx_req;
    logic           rd_ok;
    logic [RXW-1:0] rx_burst_inc;
    logic [TXW-1:0] tx_burst_inc;

    // A byte lands in the skid on every edge where our read strobe meets
    // valid data from the FT2232.
    assign push = (state_q == ST_RX_READ) && !rd_n_q && !fifo_rxf_n_i;
    assign pop  = rx_valid_o && rx_ready_i;

    assign skid_cnt_d   = skid_cnt_q + {1'b0, push} - {1'b0, pop};
    assign rx_burst_inc = rx_burst_q + RXW'(push);

    // Keep reading only if the skid can still take the byte that the next
    // strobe will return, which is what makes overflow impossible.
    assign rd_ok = !fifo_rxf_n_i && (skid_cnt_d <= 2'd1) && (rx_burst_inc < RX_MAX_C);

    assign rx_req = !fifo_rxf_n_i && (skid_cnt_q == 2'd0);
    assign tx_req = tx_valid_i && !fifo_txe_n_i;

    assign tx_ready_o   = (state_q == ST_TX_WRITE) && !fifo_txe_n_i && (tx_burst_q < TX_MAX_C);
    assign tx_xfer      = tx_valid_i && tx_ready_o;
    assign tx_burst_inc = tx_burst_q + TXW'(tx_xfer);

    always_comb begin
        state_d    = state_q;
        rd_n_d     = 1'b1;
        last_tx_d  = last_tx_q;
        rx_burst_d = rx_burst_inc;
        tx_burst_d = tx_burst_inc;

        case (state_q)
            ST_IDLE: begin
                // On contention the direction opposite the last grant wins.
                if (rx_req && (!tx_req || last_tx_q)) begin
                    state_d    = ST_RX_OE;
                    last_tx_d  = 1'b0;
                    rx_burst_d = '0;
                end else if (tx_req) begin
                    state_d    = ST_TX_WRITE;
                    last_tx_d  = 1'b1;
                    tx_burst_d = '0;
                end
            end
            ST_RX_OE: begin
                state_d = ST_RX_READ;
                rd_n_d  = !rd_ok;
            end
            ST_RX_READ: begin
                // A high strobe means nothing was pushed this edge, so the
                // read pipeline is drained and the bus can be released.
                if (rd_n_q) begin
                    state_d = ST_TURN;
                end else begin
                    rd_n_d = !rd_ok;
                end
            end
            ST_TX_WRITE: begin
                if (!tx_valid_i || fifo_txe_n_i || (tx_burst_inc >= TX_MAX_C)) begin
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge fifo_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            rd_n_q     <= 1'b1;
            last_tx_q  <= 1'b1;
            rx_burst_q <= '0;
            tx_burst_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_n_q     <= rd_n_d;
            last_tx_q  <= last_tx_d;
            rx_burst_q <= rx_burst_d;
            tx_burst_q <= tx_burst_d;
        end
    end

    always_ff @(posedge fifo_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            skid_mem_q[0] <= 8'h00;
            skid_mem_q[1] <= 8'h00;
            skid_wr_ptr_q <= 1'b0;
            skid_rd_ptr_q <= 1'b0;
            skid_cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                skid_mem_q[skid_wr_ptr_q] <= fifo_data_i;
                skid_wr_ptr_q             <= ~skid_wr_ptr_q;
            end
            if (pop) begin
                skid_rd_ptr_q <= ~skid_rd_ptr_q;
            end
            skid_cnt_q <= skid_cnt_d;
        end
    end

    assign rx_valid_o = (skid_cnt_q != 2'd0);
    assign rx_data_o  = skid_mem_q[skid_rd_ptr_q];

    // Pad controls decode straight from registered state, so the drive enable
    // and FT2232 output enable can never be active together.
    assign fifo_oe_n_o    = !((state_q == ST_RX_OE) || (state_q == ST_RX_READ));
    assign fifo_rd_n_o    = rd_n_q;
    assign fifo_data_oe_o = (state_q == ST_TX_WRITE);
    assign fifo_data_o    = fifo_data_oe_o ? tx_data_i : 8'h00;
    assign fifo_wr_n_o    = !tx_xfer;

`ifdef FT2232_SIWU_FLUSH_EN
    localparam int SIW = $clog2(SIWU_IDLE_CYCLES + 1);
    localparam logic [SIW-1:0] SIWU_MAX_C = SIW'(SIWU_IDLE_CYCLES);

    logic [SIW-1:0] idle_cnt_q, idle_cnt_d;
    logic           siwu_armed_q, siwu_armed_d;
    logic           siwu_fire;

    // The counter saturates at the threshold and waits there until the bus
    // is in IDLE or TURN, so a flush never lands in the middle of a burst.
    assign siwu_fire = siwu_armed_q && !tx_xfer && (idle_cnt_q == SIWU_MAX_C) &&
                       ((state_q == ST_IDLE) || (state_q == ST_TURN));

    always_comb begin
        idle_cnt_d   = idle_cnt_q;
        siwu_armed_d = siwu_armed_q;
        if (tx_xfer) begin
            idle_cnt_d   = '0;
            siwu_armed_d = 1'b1;
        end else if (siwu_fire) begin
            siwu_armed_d = 1'b0;
        end else if (siwu_armed_q && (idle_cnt_q < SIWU_MAX_C)) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge fifo_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            idle_cnt_q   <= '0;
            siwu_armed_q <= 1'b0;
        end else begin
            idle_cnt_q   <= idle_cnt_d;
            siwu_armed_q <= siwu_armed_d;
        end
    end

    assign fifo_siwu_o = !siwu_fire;
`else
    assign fifo_siwu_o = 1'b1;
`endif

endmodule

// File: tb/tb_ft2232_fifo_arbiter.sv
// tb_ft2232_fifo_arbiter
// ----------------------
// Self-checking bench for ft2232_fifo_arbiter. A behavioural FT2232 model
// feeds host bytes on the bus and absorbs written bytes; a transmit source
// drives the tx stream. Stimulus pushes expected bytes into scoreboard queues
// and a separate monitor pops and compares whenever the DUT hands a byte over.

module tb_ft2232_fifo_arbiter;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic       fifoRxfN = 1'b1;
    logic       fifoTxeN = 1'b0;
    logic [7:0] fifoDataIn = 8'h00;
    logic [7:0] fifoDataOut;
    logic       fifoDataOe;
    logic       fifoOeN;
    logic       fifoRdN;
    logic       fifoWrN;
    logic       fifoSiwu;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxReady = 1'b1;
    logic [7:0] txData = 8'h00;
    logic       txValid = 1'b0;
    logic       txReady;

    ft2232_fifo_arbiter dut (
        .fifo_clk_i     (clk),
        .reset_n_i      (resetN),
        .fifo_rxf_n_i   (fifoRxfN),
        .fifo_txe_n_i   (fifoTxeN),
        .fifo_data_i    (fifoDataIn),
        .fifo_data_o    (fifoDataOut),
        .fifo_data_oe_o (fifoDataOe),
        .fifo_oe_n_o    (fifoOeN),
        .fifo_rd_n_o    (fifoRdN),
        .fifo_wr_n_o    (fifoWrN),
        .fifo_siwu_o    (fifoSiwu),
        .rx_data_o      (rxData),
        .rx_valid_o     (rxValid),
        .rx_ready_i     (rxReady),
        .tx_data_i      (txData),
        .tx_valid_i     (txValid),
        .tx_ready_o     (txReady)
    );

    always #5 clk = ~clk;

    logic [7:0] hostRx[$];
    logic [7:0] expRx[$];
    logic [7:0] txSrc[$];
    logic [7:0] expTx[$];
    int         rxBursts[$];
    int         txBursts[$];
    logic [7:0] grants[$];

    int   assertCount = 0;
    int   failCount = 0;
    logic rxXfer = 1'b0;
    logic txFire = 1'b0;
    logic wrStrobe = 1'b0;
    int   txWritten = 0;
    int   rxReceived = 0;
    bit   stallArmed = 1'b0;
    int   stallAtWrite = 0;
    int   txeHold = 0;
    bit   readyToggle = 1'b0;
    int   cycleCount = 0;
    int   contention = 0;
    int   siwuPulses = 0;
    int   curRxBurst = 0;
    int   curTxBurst = 0;
    logic prevOeN = 1'b1;
    logic prevDataOe = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit toTx, input int first, input int count);
        for (int i = 0; i < count; i++) begin
            if (toTx) begin
                txSrc.push_back(8'(first + i));
                expTx.push_back(8'(first + i));
            end else begin
                hostRx.push_back(8'(first + i));
                expRx.push_back(8'(first + i));
            end
        end
    endtask

    task automatic waitRxDone(input string name, input int budget);
        int n = 0;
        while ((hostRx.size() != 0 || expRx.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_drained"}, 32'(hostRx.size() + expRx.size()), 32'd0);
        repeat (5) @(negedge clk);
    endtask

    task automatic waitTxDone(input string name, input int budget);
        int n = 0;
        while ((txSrc.size() != 0 || expTx.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_drained"}, 32'(txSrc.size() + expTx.size()), 32'd0);
        repeat (5) @(negedge clk);
    endtask

    // FT2232 bus model and stream drivers: drive on the falling edge, then
    // record which handshakes the next rising edge will complete.
    always @(negedge clk) begin
        cycleCount++;
        if (stallArmed && txWritten == stallAtWrite) begin
            txeHold = 5;
            stallArmed = 1'b0;
        end
        if (txeHold > 0) begin
            fifoTxeN = 1'b1;
            txeHold--;
        end else begin
            fifoTxeN = 1'b0;
        end
        fifoRxfN   = (hostRx.size() == 0);
        fifoDataIn = (hostRx.size() != 0) ? hostRx[0] : 8'h00;
        txValid    = (txSrc.size() != 0);
        txData     = (txSrc.size() != 0) ? txSrc[0] : 8'h00;
        rxReady    = readyToggle ? (((cycleCount / 3) % 2) == 0) : 1'b1;
        #1;
        rxXfer   = !fifoRdN && !fifoRxfN;
        txFire   = txValid && txReady;
        wrStrobe = !fifoWrN;
    end

    always @(posedge clk) begin
        if (resetN) begin
            if (rxXfer) void'(hostRx.pop_front());
            if (txFire) void'(txSrc.pop_front());
            if (wrStrobe) txWritten++;
        end
    end

    // Monitor: scoreboard compare plus burst/grant bookkeeping.
    always @(negedge clk) begin
        logic [7:0] expByte;
        #2;
        if (fifoDataOe && !fifoOeN) contention++;
        if (!fifoSiwu) siwuPulses++;
        if (!fifoOeN && prevOeN) begin
            grants.push_back(8'h52);
            curRxBurst = 0;
        end
        if (fifoDataOe && !prevDataOe) begin
            grants.push_back(8'h54);
            curTxBurst = 0;
        end
        if (rxXfer) curRxBurst++;
        if (!fifoWrN) begin
            curTxBurst++;
            if (expTx.size() != 0) begin
                expByte = expTx.pop_front();
                checkOutput("tx_data", 32'(fifoDataOut), 32'(expByte));
            end else begin
                checkOutput("tx_extra_byte", 32'(expTx.size()), 32'd1);
            end
        end
        if (fifoOeN && !prevOeN) rxBursts.push_back(curRxBurst);
        if (!fifoDataOe && prevDataOe) txBursts.push_back(curTxBurst);
        prevOeN = fifoOeN;
        prevDataOe = fifoDataOe;
        if (rxValid && rxReady) begin
            rxReceived++;
            if (expRx.size() != 0) begin
                expByte = expRx.pop_front();
                checkOutput("rx_data", 32'(rxData), 32'(expByte));
            end else begin
                checkOutput("rx_extra_byte", 32'(expRx.size()), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rBase;
        int tBase;
        int gBase;
        int base;
        int n;

        // Reset values
        #2 resetN = 1'b0;
        #1;
        checkOutput("rst_oe_n", 32'(fifoOeN), 32'd1);
        checkOutput("rst_rd_n", 32'(fifoRdN), 32'd1);
        checkOutput("rst_wr_n", 32'(fifoWrN), 32'd1);
        checkOutput("rst_siwu", 32'(fifoSiwu), 32'd1);
        checkOutput("rst_data_oe", 32'(fifoDataOe), 32'd0);
        checkOutput("rst_data_o", 32'(fifoDataOut), 32'd0);
        checkOutput("rst_rx_valid", 32'(rxValid), 32'd0);
        checkOutput("rst_tx_ready", 32'(txReady), 32'd0);
        @(negedge clk);
        #3 resetN = 1'b1;
        repeat (3) @(negedge clk);

        // RX only, 200 bytes, with first-byte latency
        $display("[TB] RX only, 200 bytes");
        rBase = rxBursts.size();
        base = rxReceived;
        #3 applyStimulus(1'b0, 0, 200);
        @(negedge clk); #2;
        checkOutput("lat_rxf_low", 32'(fifoRxfN), 32'd0);
        checkOutput("lat_oe_t0", 32'(fifoOeN), 32'd1);
        @(negedge clk); #2;
        checkOutput("lat_oe_t1", 32'(fifoOeN), 32'd0);
        checkOutput("lat_rd_t1", 32'(fifoRdN), 32'd1);
        @(negedge clk); #2;
        checkOutput("lat_rd_t2", 32'(fifoRdN), 32'd0);
        checkOutput("lat_valid_t2", 32'(rxValid), 32'd0);
        @(negedge clk); #2;
        checkOutput("lat_valid_t3", 32'(rxValid), 32'd1);
        waitRxDone("rx200", 1000);
        checkOutput("rx200_count", 32'(rxReceived - base), 32'd200);
        checkOutput("rx200_bursts", 32'(rxBursts.size() - rBase), 32'd4);
        if (rxBursts.size() - rBase == 4) begin
            checkOutput("rx200_burst0", 32'(rxBursts[rBase]), 32'd64);
            checkOutput("rx200_burst1", 32'(rxBursts[rBase + 1]), 32'd64);
            checkOutput("rx200_burst2", 32'(rxBursts[rBase + 2]), 32'd64);
            checkOutput("rx200_burst3", 32'(rxBursts[rBase + 3]), 32'd8);
        end

        // RX with rx_ready toggling every 3 cycles
        $display("[TB] RX with back-pressure");
        base = rxReceived;
        readyToggle = 1'b1;
        applyStimulus(1'b0, 8'h10, 40);
        waitRxDone("rxbp", 1000);
        readyToggle = 1'b0;
        checkOutput("rxbp_count", 32'(rxReceived - base), 32'd40);

        // TX only, 10 bytes, txe stalled after byte 4
        $display("[TB] TX only with txe stall");
        tBase = txBursts.size();
        base = txWritten;
        stallAtWrite = txWritten + 4;
        stallArmed = 1'b1;
        applyStimulus(1'b1, 8'hA0, 10);
        waitTxDone("tx10", 500);
        checkOutput("tx10_writes", 32'(txWritten - base), 32'd10);
        checkOutput("tx10_bursts", 32'(txBursts.size() - tBase), 32'd2);
        if (txBursts.size() - tBase == 2) begin
            checkOutput("tx10_burst0", 32'(txBursts[tBase]), 32'd4);
            checkOutput("tx10_burst1", 32'(txBursts[tBase + 1]), 32'd6);
        end

        // Both directions pending: alternating 64-byte grants
        $display("[TB] both directions pending");
        rBase = rxBursts.size();
        tBase = txBursts.size();
        gBase = grants.size();
        applyStimulus(1'b0, 0, 128);
        applyStimulus(1'b1, 8'h40, 128);
        n = 0;
        while ((hostRx.size() + expRx.size() + txSrc.size() + expTx.size()) != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("both_drained", 32'(hostRx.size() + expRx.size() + txSrc.size() + expTx.size()), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("both_grants", 32'(grants.size() - gBase), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (gBase + i < grants.size())
                checkOutput($sformatf("both_grant%0d", i), 32'(grants[gBase + i]), (i % 2 == 0) ? 32'h52 : 32'h54);
        end
        for (int i = 0; i < 2; i++) begin
            if (rBase + i < rxBursts.size())
                checkOutput($sformatf("both_rxburst%0d", i), 32'(rxBursts[rBase + i]), 32'd64);
            if (tBase + i < txBursts.size())
                checkOutput($sformatf("both_txburst%0d", i), 32'(txBursts[tBase + i]), 32'd64);
        end

        // Reset pulse mid RX burst after byte 10
        $display("[TB] reset during RX burst");
        base = rxReceived;
        applyStimulus(1'b0, 8'h80, 30);
        n = 0;
        while (rxReceived < base + 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rst_mid_reached", 32'(rxReceived >= base + 10), 32'd1);
        @(negedge clk);
        #3 resetN = 1'b0;
        #1;
        checkOutput("rst_mid_oe_n", 32'(fifoOeN), 32'd1);
        checkOutput("rst_mid_rd_n", 32'(fifoRdN), 32'd1);
        checkOutput("rst_mid_rx_valid", 32'(rxValid), 32'd0);
        checkOutput("rst_mid_data_oe", 32'(fifoDataOe), 32'd0);
        expRx = hostRx;
        @(negedge clk);
        #3 resetN = 1'b1;
        #1;
        checkOutput("rst_mid_no_stale", 32'(rxValid), 32'd0);
        waitRxDone("rst_mid", 500);

`ifdef FT2232_SIWU_FLUSH_EN
        $display("[TB] send-immediate flush");
        repeat (50) @(negedge clk);
        base = siwuPulses;
        applyStimulus(1'b1, 8'h33, 3);
        waitTxDone("siwu", 100);
        repeat (100) @(negedge clk);
        checkOutput("siwu_pulses", 32'(siwuPulses - base), 32'd1);
`else
        checkOutput("siwu_tied", 32'(siwuPulses), 32'd0);
`endif

        checkOutput("contention", 32'(contention), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
